// File: rtl/i2s_pkg.sv
// Shared types for the I2S receiver: FSM state encoding and channel codes.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for one asynchronous input, plus rise/change detection
// against a reference level that is refreshed whenever i_take is high.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic ck,
  input  logic rst,
  input  logic i_d,
  input  logic i_take,
  output logic o_level,
  output logic o_rise,
  output logic o_change
);

  logic [STAGES-1:0] r_sync;
  logic              r_ref;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_ref  <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      if (i_take) r_ref <= r_sync[STAGES-1];
    end
  end

  // Outputs depend on flops only, so all instances stay cycle-aligned.
  assign o_level  = r_sync[STAGES-1];
  assign o_rise   = r_sync[STAGES-1] & ~r_ref;
  assign o_change = r_sync[STAGES-1] ^ r_ref;

endmodule

// File: rtl/i2s_rx.sv
// I2S deserialiser: captures M-bit MSB-first words of one channel (both channels
// when I2S_RX_STEREO_EN is defined) and presents each with a one-cycle strobe.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int M           = 24,
  parameter bit CHANNEL     = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                ck,
  input  logic                rst,
  input  logic                sclk,
  input  logic                lrclk,
  input  logic                sdata,
  output logic signed [M-1:0] sample_out,
  output logic                sample_valid,
`ifdef I2S_RX_STEREO_EN
  output logic                chan,
`endif
  output state_t              o_dbg_state
);

  localparam int            CW   = $clog2(M);
  localparam logic [CW-1:0] LAST = CW'(M - 1);

  logic w_sclk_lvl, w_sclk_rise, w_sclk_chg;
  logic w_lr_lvl, w_lr_rise, w_lr_chg;
  logic w_sd_lvl, w_sd_rise, w_sd_chg;
  logic w_lr_edge, w_word_done, w_want;
  logic [M-1:0] w_shift_in;
  logic w_unused;

  state_t               r_state, w_next;
  logic                 r_armed;
  logic                 r_ch;
  logic [CW-1:0]        r_cnt;
  logic [M-1:0]         r_shift;
  logic signed [M-1:0]  r_sample;
  logic                 r_valid;
  logic                 r_chan;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .ck(ck), .rst(rst), .i_d(sclk), .i_take(1'b1),
    .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_change(w_sclk_chg)
  );

  // lrclk reference only moves on sclk rises, so its change output is the
  // word-select edge as seen by the bit clock.
  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_lrclk (
    .ck(ck), .rst(rst), .i_d(lrclk), .i_take(w_sclk_rise),
    .o_level(w_lr_lvl), .o_rise(w_lr_rise), .o_change(w_lr_chg)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_sdata (
    .ck(ck), .rst(rst), .i_d(sdata), .i_take(1'b1),
    .o_level(w_sd_lvl), .o_rise(w_sd_rise), .o_change(w_sd_chg)
  );

  // The first sclk rise after reset only seeds the lrclk reference.
  assign w_lr_edge  = w_sclk_rise & r_armed & w_lr_chg;
  assign w_shift_in = {r_shift[M-2:0], w_sd_lvl};

`ifdef I2S_RX_STEREO_EN
  assign w_want   = 1'b1;
  assign w_unused = ^{w_sclk_lvl, w_sclk_chg, w_lr_rise, w_sd_rise, w_sd_chg, CHANNEL};
`else
  assign w_want   = (r_ch == CHANNEL);
  assign w_unused = ^{w_sclk_lvl, w_sclk_chg, w_lr_rise, w_sd_rise, w_sd_chg, r_chan};
`endif

  always_comb begin
    w_next      = r_state;
    w_word_done = 1'b0;
    if (w_sclk_rise) begin
      case (r_state)
        IDLE, DONE: if (w_lr_edge) w_next = DELAY;
        DELAY:      w_next = w_lr_edge ? DELAY : SHIFT;
        SHIFT: begin
          if (w_lr_edge) begin
            w_next = DELAY;
          end else if (r_cnt == LAST) begin
            w_next      = DONE;
            w_word_done = 1'b1;
          end
        end
        default:    w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_sclk_rise) r_armed <= 1'b1;
    end
  end

  // The rise that reveals the lrclk edge carries the delay bit; the next rise
  // (leaving DELAY) already carries the MSB, so r_cnt counts bits held.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_ch    <= CH_LEFT;
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (w_sclk_rise) begin
      if (w_lr_edge) begin
        r_ch <= w_lr_lvl;
      end else if (r_state == DELAY) begin
        r_shift <= w_shift_in;
        r_cnt   <= CW'(1);
      end else if (r_state == SHIFT) begin
        r_shift <= w_shift_in;
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_sample <= '0;
      r_valid  <= 1'b0;
      r_chan   <= CH_LEFT;
    end else begin
      r_valid <= w_word_done & w_want;
      if (w_word_done & w_want) begin
        r_sample <= $signed(w_shift_in);
        r_chan   <= r_ch;
      end
    end
  end

  assign sample_out   = r_sample;
  assign sample_valid = r_valid;
  assign o_dbg_state  = r_state;
`ifdef I2S_RX_STEREO_EN
  assign chan = r_chan;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: drives I2S slots, predicts captured words into a queue and
// compares them against each strobe. Define I2S_RX_STEREO_EN for the stereo build.
module tb_i2s_rx;
  import i2s_pkg::*;

  localparam int  M       = 24;
  localparam bit  CHANNEL = 1'b0;
  localparam int  SLOT    = 32;
  localparam time T_SCLK  = 80;
`ifdef I2S_RX_STEREO_EN
  localparam bit  STEREO  = 1'b1;
`else
  localparam bit  STEREO  = 1'b0;
`endif

  logic                ck = 1'b0;
  logic                rst;
  logic                sclk;
  logic                lrclk;
  logic                sdata;
  logic signed [M-1:0] sample_out;
  logic                sample_valid;
  logic                chan;
  state_t              dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [M:0]   exp_q[$];
  time          t_q[$];
  logic [M-1:0] m_last = '0;
  logic         m_lr   = 1'b1;

  i2s_rx #(.M(M), .CHANNEL(CHANNEL), .SYNC_STAGES(2)) dut (
    .ck(ck), .rst(rst), .sclk(sclk), .lrclk(lrclk), .sdata(sdata),
    .sample_out(sample_out), .sample_valid(sample_valid),
`ifdef I2S_RX_STEREO_EN
    .chan(chan),
`endif
    .o_dbg_state(dbg_state)
  );

`ifndef I2S_RX_STEREO_EN
  assign chan = 1'b0;
`endif

  // clock / reset
  always #5 ck = ~ck;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // scoreboard
  always @(negedge ck) begin
    logic [M:0] e;
    if (!rst && sample_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_strobe", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("sample_out", 64'($unsigned(sample_out)), 64'(e[M-1:0]));
`ifdef I2S_RX_STEREO_EN
        check_eq("chan", 64'(chan), 64'(e[M]));
`endif
        if (e[M] == CH_LEFT) t_q.push_back($time);
      end
    end
  end

  // drivers
  task automatic sclk_bit(input logic lr, input logic d);
    sclk = 1'b0; lrclk = lr; sdata = d;
    #(T_SCLK/2);
    sclk = 1'b1;
    #(T_SCLK/2);
  endtask

  task automatic send_idle(input int n, input logic lr);
    for (int i = 0; i < n; i++) sclk_bit(lr, 1'b0);
    m_lr = lr;
  endtask

  // Bit 0 of a slot is the I2S delay bit; bits 1..M carry the word MSB first.
  task automatic send_slot(input logic lr, input logic [M-1:0] word, input int nbits, input int rst_at);
    logic has_edge;
    logic d;
    has_edge = (lr != m_lr);
    if (has_edge && nbits >= M + 1 && !(rst_at >= 0 && rst_at < nbits) &&
        (STEREO || lr == CHANNEL)) begin
      exp_q.push_back({lr, word});
      m_last = word;
    end
    for (int i = 0; i < nbits; i++) begin
      d = (i >= 1 && i <= M) ? word[M-i] : 1'b0;
      if (i == rst_at) begin
        sclk = 1'b0; lrclk = lr; sdata = d;
        rst = 1'b1;
        #1;
        check_eq("rst_mid_sample", 64'($unsigned(sample_out)), 64'd0);
        check_eq("rst_mid_valid", 64'(sample_valid), 64'd0);
        check_eq("rst_mid_state", 64'(dbg_state), 64'(IDLE));
        #19;
        rst = 1'b0;
        m_last = '0;
        #(T_SCLK/2 - 20);
        sclk = 1'b1;
        #(T_SCLK/2);
      end else begin
        sclk_bit(lr, d);
      end
    end
    m_lr = lr;
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b0; lrclk = 1'b1; sdata = 1'b0;
    #22;
    check_eq("reset_sample", 64'($unsigned(sample_out)), 64'd0);
    check_eq("reset_valid", 64'(sample_valid), 64'd0);
    check_eq("reset_state", 64'(dbg_state), 64'(IDLE));
    rst = 1'b0;
    send_idle(4, 1'b1);

    // 1: one left word, then a right word
    send_slot(1'b0, 24'h800001, SLOT, -1);
    send_slot(1'b1, 24'h0F0F0F, SLOT, -1);
    check_eq("t1_hold", 64'($unsigned(sample_out)), 64'(m_last));

    // 2: short left slot then a right-only word
    send_slot(1'b0, 24'h000000, 2, -1);
    send_slot(1'b1, 24'h123456, SLOT, -1);
    check_eq("t2_hold", 64'($unsigned(sample_out)), 64'(m_last));

    // 3: left word aborted after 10 bits, then a full left word
    send_slot(1'b0, 24'h5A5A5A, 10, -1);
    send_slot(1'b1, 24'h000000, SLOT, -1);
    send_slot(1'b0, 24'h123456, SLOT, -1);
    send_slot(1'b1, 24'h000000, SLOT, -1);
    check_eq("t3_hold", 64'($unsigned(sample_out)), 64'(m_last));

    // 4: reset in the middle of a left word
    send_slot(1'b0, 24'hABCDEF, SLOT, 12);
    send_slot(1'b1, 24'h000000, SLOT, -1);
    send_slot(1'b0, 24'h000001, SLOT, -1);
    send_slot(1'b1, 24'h000000, SLOT, -1);
    check_eq("t4_hold", 64'($unsigned(sample_out)), 64'(m_last));

    // 5: back-to-back frames, strobe spacing of one frame
    t_q.delete();
    send_slot(1'b0, 24'h000001, SLOT, -1);
    send_slot(1'b1, 24'h000000, SLOT, -1);
    send_slot(1'b0, 24'h000002, SLOT, -1);
    send_slot(1'b1, 24'h000000, SLOT, -1);
    send_slot(1'b0, 24'h000003, SLOT, -1);
    send_slot(1'b1, 24'h000000, SLOT, -1);
    send_slot(1'b0, 24'hFFFFFF, SLOT, -1);
    send_slot(1'b1, 24'h000000, SLOT, -1);
    check_eq("t5_strobes", 64'(t_q.size()), 64'd4);
    for (int k = 1; k < 4; k++) begin
      if (t_q.size() > k)
        check_eq("t5_spacing", 64'(t_q[k] - t_q[k-1]), 64'(2 * SLOT * T_SCLK));
    end

`ifdef I2S_RX_STEREO_EN
    // 6: both channels captured with channel tags
    send_slot(1'b0, 24'h7FFFFF, SLOT, -1);
    send_slot(1'b1, 24'hFFFFFF, SLOT, -1);
    check_eq("t6_hold", 64'($unsigned(sample_out)), 64'(m_last));
`endif

    #200;
    check_eq("pending", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
